// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types, funct3 encodings and alignment helper for the load/store unit
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   // Halfwords need an even address, words a fully aligned one; bytes never fault.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == LS_H[1:0]) && lo[0]) ||
             ((f3[1:0] == LS_W[1:0]) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - req/ack data-bus interface between the load/store unit and data memory
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - lsu_align: store byte-lane steering and load lane select/extension
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [1:0]  lane;
   logic [31:0] shifted;
   logic        sext;

   always_comb begin
      lane       = 2'b00;
      be         = 4'b1111;
      wdata_lane = wdata;
      sext       = ~funct3[2];
      case (funct3[1:0])
         LS_B[1:0]: begin
            lane       = addr_lo;
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         LS_H[1:0]: begin
            lane       = {addr_lo[1], 1'b0};
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase

      // Bring the addressed lane down to bit 0, then extend by size/sign.
      shifted = rdata_raw >> {lane, 3'b000};
      case (funct3[1:0])
         LS_B[1:0]: rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
         LS_H[1:0]: rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
         default:   rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory stage FSM with req/ack bus, wait timeout and stall; optional LSU_MISALIGN_CHECK_EN
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               dbus_re,
   input  logic               dbus_we,
   input  logic [2:0]         funct3,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic               stall,
   output logic [31:0]        rdata,
   output logic               rdata_valid,
   output logic               bus_err,
   load_store_unit_if.master  bus
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);

   lsu_state_t state, state_next;

   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic              err_q;
   logic [WAIT_W-1:0] wait_cnt;

   logic        access;
   logic        misalign_hit;
   logic        timeout;
   logic [3:0]  be_lane;
   logic [31:0] wdata_lane;
   logic [31:0] rdata_ext;

   assign access  = start && (dbus_re || dbus_we);
   assign timeout = (wait_cnt >= WAIT_LAST);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign_hit = misaligned(funct3, addr[1:0]);
`else
   assign misalign_hit = 1'b0;
`endif

   lsu_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata_raw  (bus.mem_rdata),
      .be         (be_lane),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Bus outputs are zeroed outside REQ so an async reset drops the request at once.
   always_comb begin
      state_next    = state;
      stall         = 1'b0;
      rdata_valid   = 1'b0;
      bus_err       = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_be    = 4'h0;
      bus.mem_wdata = 32'h0;
      case (state)
         IDLE: begin
            if (access) begin
               stall      = 1'b1;
               state_next = misalign_hit ? DONE : REQ;
            end
         end
         REQ: begin
            stall         = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = {addr_q[31:2], 2'b00};
            bus.mem_be    = be_lane;
            bus.mem_wdata = wdata_lane;
            if (bus.mem_ack || timeout) state_next = DONE;
         end
         DONE: begin
            rdata_valid = !we_q && !err_q;
            bus_err     = err_q;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         funct3_q <= 3'b000;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
         rdata    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  addr_q   <= addr;
                  wdata_q  <= wdata;
                  funct3_q <= funct3;
                  we_q     <= dbus_we;
                  err_q    <= misalign_hit;
                  wait_cnt <= '0;
                  if (misalign_hit && !dbus_we) rdata <= 32'h0;
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  if (!we_q) rdata <= rdata_ext;
               end else if (timeout) begin
                  err_q <= 1'b1;
                  if (!we_q) rdata <= 32'h0;
               end else if (wait_cnt != WAIT_SAT) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && start)
         assert (!(dbus_re && dbus_we))
            else $error("lsu: dbus_re and dbus_we both set, access treated as store");
   end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit (MAX_WAIT=4)
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        dbus_re;
   logic        dbus_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   load_store_unit_if bus_if ();

   load_store_unit #(.MAX_WAIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dbus_re     (dbus_re),
      .dbus_we     (dbus_we),
      .funct3      (funct3),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .bus_err     (bus_err),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single IDLE cycle, then withdraws it.
   task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      start = 1'b1; dbus_re = re; dbus_we = we; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      chk("issue_stall", {31'b0, stall}, 32'd1);
      chk("issue_noreq", {31'b0, bus_if.mem_req}, 32'd0);
      tick();
      start = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0;
   endtask

   // Single-cycle-ack load: checks lanes in REQ and the write-back pulse in DONE.
   task automatic load1(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [3:0] exp_be, input logic [31:0] raw, input logic [31:0] exp_rd);
      issue(1'b1, 1'b0, f3, a, 32'h0);
      bus_if.mem_ack = 1'b1; bus_if.mem_rdata = raw;
      @(negedge clk);
      chk({tag, "_be"}, {28'b0, bus_if.mem_be}, {28'b0, exp_be});
      chk({tag, "_we"}, {31'b0, bus_if.mem_we}, 32'd0);
      tick();
      bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
      @(negedge clk);
      chk({tag, "_valid"}, {31'b0, rdata_valid}, 32'd1);
      chk({tag, "_rdata"}, rdata, exp_rd);
      chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
      tick();
      @(negedge clk);
      chk({tag, "_valid_drop"}, {31'b0, rdata_valid}, 32'd0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0;
      funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
      bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
      tick();
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_req", {31'b0, bus_if.mem_req}, 32'd0);
      chk("rst_be", {28'b0, bus_if.mem_be}, 32'd0);
      chk("rst_addr", bus_if.mem_addr, 32'h0);
      chk("rst_wdata", bus_if.mem_wdata, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_valid", {31'b0, rdata_valid}, 32'd0);
      chk("rst_err", {31'b0, bus_err}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // SW 0x100, ack in first REQ cycle
      issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      chk("sw_req", {31'b0, bus_if.mem_req}, 32'd1);
      chk("sw_we", {31'b0, bus_if.mem_we}, 32'd1);
      chk("sw_be", {28'b0, bus_if.mem_be}, 32'hF);
      chk("sw_addr", bus_if.mem_addr, 32'h100);
      chk("sw_wdata", bus_if.mem_wdata, 32'hDEADBEEF);
      chk("sw_stall", {31'b0, stall}, 32'd1);
      tick();
      bus_if.mem_ack = 1'b0;
      @(negedge clk);
      chk("sw_done_stall", {31'b0, stall}, 32'd0);
      chk("sw_no_valid", {31'b0, rdata_valid}, 32'd0);
      chk("sw_no_err", {31'b0, bus_err}, 32'd0);
      chk("sw_done_req", {31'b0, bus_if.mem_req}, 32'd0);
      tick();

      // SB 0x103
      issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5);
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      chk("sb_be", {28'b0, bus_if.mem_be}, 32'h8);
      chk("sb_wdata", bus_if.mem_wdata, 32'hA5A5A5A5);
      chk("sb_addr", bus_if.mem_addr, 32'h100);
      tick();
      bus_if.mem_ack = 1'b0;
      tick();

      // SH 0x102
      issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h12341234);
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      chk("sh_be", {28'b0, bus_if.mem_be}, 32'hC);
      chk("sh_wdata", bus_if.mem_wdata, 32'h12341234);
      tick();
      bus_if.mem_ack = 1'b0;
      tick();

      load1("lb",  3'b000, 32'h101, 4'b0010, 32'h00008000, 32'hFFFFFF80);
      load1("lbu", 3'b100, 32'h101, 4'b0010, 32'h00008000, 32'h00000080);
      load1("lhu", 3'b101, 32'h102, 4'b1100, 32'hBEEF0000, 32'h0000BEEF);
      load1("lh",  3'b001, 32'h102, 4'b1100, 32'h80010000, 32'hFFFF8001);
      load1("lw",  3'b010, 32'h104, 4'b1111, 32'h12345678, 32'h12345678);

      // LW with ack withheld 3 cycles
      issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_req", {31'b0, bus_if.mem_req}, 32'd1);
         chk("wait_addr", bus_if.mem_addr, 32'h200);
         chk("wait_stall", {31'b0, stall}, 32'd1);
         tick();
      end
      bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("wait_req4", {31'b0, bus_if.mem_req}, 32'd1);
      chk("wait_stall4", {31'b0, stall}, 32'd1);
      chk("wait_valid_early", {31'b0, rdata_valid}, 32'd0);
      tick();
      bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
      @(negedge clk);
      chk("wait_valid", {31'b0, rdata_valid}, 32'd1);
      chk("wait_rdata", rdata, 32'hCAFEF00D);
      chk("wait_err", {31'b0, bus_err}, 32'd0);
      tick();

      // LW with no ack: timeout after 4 REQ cycles
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to_req", {31'b0, bus_if.mem_req}, 32'd1);
         chk("to_err_early", {31'b0, bus_err}, 32'd0);
         tick();
      end
      @(negedge clk);
      chk("to_err", {31'b0, bus_err}, 32'd1);
      chk("to_valid", {31'b0, rdata_valid}, 32'd0);
      chk("to_rdata", rdata, 32'h0);
      chk("to_req_done", {31'b0, bus_if.mem_req}, 32'd0);
      chk("to_stall_done", {31'b0, stall}, 32'd0);
      tick();
      @(negedge clk);
      chk("to_err_drop", {31'b0, bus_err}, 32'd0);
      chk("to_idle_req", {31'b0, bus_if.mem_req}, 32'd0);
      tick();

      // Stray ack in IDLE and start without re/we
      bus_if.mem_ack = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("noop_stall", {31'b0, stall}, 32'd0);
      tick();
      bus_if.mem_ack = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("noop_req", {31'b0, bus_if.mem_req}, 32'd0);
      chk("noop_valid", {31'b0, rdata_valid}, 32'd0);
      tick();

      // Async reset during REQ
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
      @(negedge clk);
      chk("rstreq_req_pre", {31'b0, bus_if.mem_req}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rstreq_req", {31'b0, bus_if.mem_req}, 32'd0);
      chk("rstreq_stall", {31'b0, stall}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rstreq_valid", {31'b0, rdata_valid}, 32'd0);
      chk("rstreq_err", {31'b0, bus_err}, 32'd0);
      chk("rstreq_rdata", rdata, 32'h0);
      tick();

`ifdef LSU_MISALIGN_CHECK_EN
      // Misaligned LW: straight to DONE with bus_err, no bus request
      issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
      @(negedge clk);
      chk("mis_err", {31'b0, bus_err}, 32'd1);
      chk("mis_req", {31'b0, bus_if.mem_req}, 32'd0);
      chk("mis_valid", {31'b0, rdata_valid}, 32'd0);
      chk("mis_stall", {31'b0, stall}, 32'd0);
      tick();
`else
      // Unaligned LW proceeds as a full-word access
      load1("lw_unal", 3'b010, 32'h102, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
